// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for an 8-bit Galois LFSR generator whose polynomial is
// x^8 + x^6 + x^5 + x + 1.
//
// Each valid beat carries the generator's full state word. The checker:
//   - seeds itself from the first nonzero word it sees (HUNT),
//   - needs a run of correct predictions before it declares lock (SYNC),
//   - once locked, predicts each word, flags mismatches and counts them.
//     While locked it keeps predicting from its own prediction after a
//     mismatch ("flywheel"), so one corrupted word cannot re-seed it.
//
// Parameters:
//   LOCK_CNT   consecutive correct predictions in SYNC needed to lock (>=1)
//   UNLOCK_ERR consecutive mispredictions in LOCKED that drop lock (>=1)
//   ERR_W      width of the saturating error counter
//
// Ports:
//   clk        clock; all logic on the rising edge
//   rst_n      synchronous, active-low reset
//   din_valid  din carries a beat this cycle
//   din[7:0]   received LFSR state word
//   err_clr    synchronous clear of err_cnt
//   locked     checker is in LOCKED
//   state[1:0] 0=HUNT, 1=SYNC, 2=LOCKED
//   err_pulse  previous valid beat mismatched while LOCKED
//   err_cnt    saturating count of LOCKED mismatches
//   expected   word predicted for the next valid beat
//
// Build option:
//   LFSR_CHK_ERRCNT_EN  when defined, err_cnt/err_clr are implemented;
//                       otherwise err_cnt reads 0 and err_clr is ignored.
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       expected
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // One generator step: shift left, feed bit 7 back into taps 6, 5, 1 and 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n[7] = s[6];
    n[6] = s[5] ^ s[7];
    n[5] = s[4] ^ s[7];
    n[4] = s[3];
    n[3] = s[2];
    n[2] = s[1];
    n[1] = s[0] ^ s[7];
    n[0] = s[7];
    return n;
  endfunction

  state_e          state_q;
  logic            locked_q;
  logic            err_pulse_q;
  logic [7:0]      expected_q;
  logic [MW-1:0]   match_cnt_q;
  logic [EW-1:0]   miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      expected_q  <= 8'h00;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          HUNT: begin
            // The all-zero word is the LFSR lock-up state and cannot seed.
            if (din != 8'h00) begin
              expected_q  <= lfsr_step(din);
              match_cnt_q <= '0;
              state_q     <= SYNC;
            end
          end
          SYNC: begin
            if (din == expected_q) begin
              expected_q <= lfsr_step(din);
              if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
                state_q     <= LOCKED;
                locked_q    <= 1'b1;
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + MW'(1);
              end
            end else if (din != 8'h00) begin
              // Still hunting for alignment: re-seed from the new word.
              expected_q  <= lfsr_step(din);
              match_cnt_q <= '0;
            end else begin
              state_q     <= HUNT;
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (din == expected_q) begin
              expected_q <= lfsr_step(din);
              miss_cnt_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              // Flywheel: advance our own prediction, ignore the bad word.
              expected_q  <= lfsr_step(expected_q);
              if (miss_cnt_q == EW'(UNLOCK_ERR - 1)) begin
                state_q    <= HUNT;
                locked_q   <= 1'b0;
                miss_cnt_q <= '0;
              end else begin
                miss_cnt_q <= miss_cnt_q + EW'(1);
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  logic             lock_miss;
  logic [ERR_W-1:0] err_cnt_q;

  assign lock_miss = din_valid && (state_q == LOCKED) && (din != expected_q);

  // Clear wins over a same-cycle increment; the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (lock_miss && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Self-checking bench for lfsr_checker (LOCK_CNT=4, UNLOCK_ERR=3, ERR_W=4).
// A behavioural model of the checker's rules runs alongside the DUT; a compare
// process checks every output on every falling edge. Directed scenarios are
// additionally pinned with hand-computed literal values, followed by a long
// randomized run.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_ERR = 3;
  localparam int ERR_W      = 4;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;
`ifdef LFSR_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             din_valid;
  logic [7:0]       din;
  logic             err_clr;
  logic             locked;
  logic [1:0]       state;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       expected;

  lfsr_checker #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_ERR(UNLOCK_ERR),
    .ERR_W     (ERR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_valid(din_valid),
    .din      (din),
    .err_clr  (err_clr),
    .locked   (locked),
    .state    (state),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .expected (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // ---------------- behavioural model ----------------
  int       m_mode;   // 0 hunt, 1 sync, 2 locked
  int       m_run;    // correct predictions seen in sync
  int       m_miss;   // consecutive misses while locked
  int       m_errs;   // locked misses since last clear (unsaturated)
  bit       m_pulse;
  bit [7:0] m_exp;

  // Galois step as multiply-by-x modulo the polynomial (0x163 -> 0x63).
  function automatic bit [7:0] nxt(input bit [7:0] s);
    bit [8:0] w;
    w = {s, 1'b0};
    if (w[8]) w = w ^ 9'h163;
    return w[7:0];
  endfunction

  function automatic int err_model();
    if (!CNT_EN) return 0;
    return (m_errs > ERR_MAX) ? ERR_MAX : m_errs;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_miss = 0; m_errs = 0; m_pulse = 0; m_exp = 8'h00;
    end else begin
      m_pulse = 0;
      if (din_valid) begin
        if (m_mode == 0) begin
          if (din != 8'h00) begin
            m_exp = nxt(din); m_run = 0; m_mode = 1;
          end
        end else if (m_mode == 1) begin
          if (din == m_exp) begin
            m_run++;
            m_exp = nxt(din);
            if (m_run >= LOCK_CNT) begin
              m_mode = 2; m_miss = 0;
            end
          end else if (din != 8'h00) begin
            m_exp = nxt(din); m_run = 0;
          end else begin
            m_mode = 0;
          end
        end else begin
          if (din == m_exp) begin
            m_exp = nxt(din); m_miss = 0;
          end else begin
            m_pulse = 1; m_errs++; m_miss++;
            m_exp = nxt(m_exp);
            if (m_miss >= UNLOCK_ERR) begin
              m_mode = 0; m_miss = 0;
            end
          end
        end
      end
      if (err_clr) m_errs = 0;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests += 5;
      if (int'(state) != m_mode) begin
        n_fail++;
        $display("[TB] FAIL state @%0t: got %0d want %0d", $time, state, m_mode);
      end
      if (locked !== (m_mode == 2)) begin
        n_fail++;
        $display("[TB] FAIL locked @%0t: got %0b want %0b", $time, locked, m_mode == 2);
      end
      if (err_pulse !== m_pulse) begin
        n_fail++;
        $display("[TB] FAIL err_pulse @%0t: got %0b want %0b", $time, err_pulse, m_pulse);
      end
      if (int'(err_cnt) != err_model() || $isunknown(err_cnt)) begin
        n_fail++;
        $display("[TB] FAIL err_cnt @%0t: got %0d want %0d", $time, err_cnt, err_model());
      end
      if (expected !== m_exp) begin
        n_fail++;
        $display("[TB] FAIL expected @%0t: got %02h want %02h", $time, expected, m_exp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input bit v, input bit [7:0] d, input bit c, input bit r);
    din_valid = v;
    din       = d;
    err_clr   = c;
    rst_n     = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic beat(input bit [7:0] d);
    tick(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d want %0d", nm, act, want);
    end else begin
      $display("[TB] check %s = %0d ok", nm, act);
    end
  endtask

  task automatic lock_up();
    beat(8'h01); beat(8'h02); beat(8'h04); beat(8'h08); beat(8'h10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit [7:0] w;
    int r;
    din_valid = 1'b0; din = 8'h00; err_clr = 1'b0; rst_n = 1'b0;
    @(posedge clk); model_step(); @(negedge clk);
    chk_en = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_state", int'(state), 0);
    chk("reset_expected", int'(expected), 0);

    // Model self-pin against the hand examples.
    chk("f_01", int'(nxt(8'h01)), 8'h02);
    chk("f_80", int'(nxt(8'h80)), 8'h63);

    // Acquire lock.
    beat(8'h01);
    chk("seed_sync", int'(state), 1);
    beat(8'h02); beat(8'h04); beat(8'h08);
    chk("not_yet_locked", int'(locked), 0);
    beat(8'h10);
    chk("locked_after_10", int'(locked), 1);
    chk("expected_20", int'(expected), 8'h20);

    // Single corrupted word, recovered by flywheel.
    beat(8'h20); beat(8'h40); beat(8'h55);
    chk("pulse_on_55", int'(err_pulse), 1);
    chk("errcnt_1", int'(err_cnt), CNT_EN ? 1 : 0);
    chk("still_locked", int'(locked), 1);
    chk("flywheel_exp", int'(expected), 8'h63);
    beat(8'h63);
    chk("pulse_clear", int'(err_pulse), 0);
    chk("expected_c6", int'(expected), 8'hC6);

    // Idle cycle with err_clr, then three consecutive bad words.
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_idle", int'(err_cnt), 0);
    beat(8'hAA); beat(8'hAA);
    chk("locked_after_2", int'(locked), 1);
    beat(8'hAA);
    chk("errcnt_3", int'(err_cnt), CNT_EN ? 3 : 0);
    chk("unlocked", int'(locked), 0);
    chk("hunt_after", int'(state), 0);

    // Zero words never seed.
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) beat(8'h00);
    chk("zeros_hunt", int'(state), 0);

    // Saturation with alternating bad/good beats, then clear on a bad beat.
    lock_up();
    for (int i = 0; i < 20; i++) begin
      beat(m_exp ^ 8'hFF);
      beat(m_exp);
    end
    chk("errcnt_sat", int'(err_cnt), CNT_EN ? 15 : 0);
    chk("sat_locked", int'(locked), 1);
    tick(1'b1, m_exp ^ 8'h01, 1'b1, 1'b1);
    chk("clr_beats_inc", int'(err_cnt), 0);
    chk("clr_pulse", int'(err_pulse), 1);

    // Reset mid-lock with err_cnt=2.
    beat(m_exp);
    beat(m_exp ^ 8'h10);
    beat(m_exp);
    beat(m_exp ^ 8'h10);
    chk("errcnt_2", int'(err_cnt), CNT_EN ? 2 : 0);
    tick(1'b1, 8'h33, 1'b1, 1'b0);
    chk("rst_state", int'(state), 0);
    chk("rst_errcnt", int'(err_cnt), 0);
    chk("rst_exp", int'(expected), 0);

    // Randomized run.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        w = (m_mode == 0) ? 8'($urandom_range(1, 255)) : m_exp;
      end else if (r < 85) begin
        w = 8'($urandom_range(0, 255));
      end else if (r < 92) begin
        w = 8'h00;
      end else begin
        w = m_exp ^ (8'h01 << $urandom_range(0, 7));
      end
      tick($urandom_range(0, 99) < 85, w, $urandom_range(0, 49) == 0,
           $urandom_range(0, 299) != 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side checker for the 8-bit Galois LFSR pattern generator (polynomial x^8 + x^6 + x^5 + x + 1). It takes the generator's full 8-bit state word each valid beat, self-synchronises to it, then predicts every subsequent word and flags mismatches. It sits at the far end of a link or loopback path under test and reports lock status and a saturating error count to the status registers.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive correct predictions required to declare lock (≥1)
- UNLOCK_ERR, 3: consecutive mispredictions while locked that drop lock (≥1)
- ERR_W, 16: width of error counter

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- din_valid  input  1  din carries a beat this cycle
- din  input  8  received LFSR state word; bit i equals generator state bit i
- err_clr  input  1  synchronous clear of err_cnt
- locked  output  1  checker is in LOCKED
- state  output  2  0=HUNT, 1=SYNC, 2=LOCKED
- err_pulse  output  1  one-cycle flag: previous valid beat mismatched while LOCKED
- err_cnt  output  ERR_W  saturating count of LOCKED mismatches
- expected  output  8  word predicted for the next valid beat

## Operation
- Step function f(s): n7=s6; n6=s5^s7; n5=s4^s7; n4=s3; n3=s2; n2=s1; n1=s0^s7; n0=s7. Example: f(0x01)=0x02, f(0x80)=0x63.
- din_valid low: all state held; err_pulse deasserts.
- HUNT: valid nonzero din → expected<=f(din), match count<=0, go SYNC. Zero din ignored (stay HUNT).
- SYNC: valid din==expected → match count+1, expected<=f(din); when count reaches LOCK_CNT go LOCKED, clear consecutive-error count. Mismatch: nonzero din → reseed expected<=f(din), count<=0, stay SYNC; zero din → HUNT.
- LOCKED: valid din==expected → expected<=f(din), consecutive-error count<=0. Mismatch → err_pulse, err_cnt+1 (saturates at 2^ERR_W-1), consecutive count+1, expected<=f(expected) (flywheel; din not used for reseed). When consecutive count reaches UNLOCK_ERR go HUNT.
- All-zero din while LOCKED is an ordinary mismatch.
- err_clr: err_cnt<=0; takes priority over a same-cycle increment. Does not affect state or lock.
- err_cnt is never cleared by loss of lock, only by reset or err_clr.

## Timing
- All outputs registered; update on the edge that samples the valid beat, visible the following cycle.
- Lock latency: locked rises the cycle after the (LOCK_CNT+1)-th consecutive correct valid beat (1 seed + LOCK_CNT matches).
- err_pulse high exactly one cycle per mismatching LOCKED beat; back-to-back mismatching beats give continuous high.
- Unlock: locked falls the cycle after the UNLOCK_ERR-th consecutive mismatch; that beat still pulses err_pulse and counts.
- Reset (any state, mid-lock included): next edge gives state=HUNT, locked=0, err_pulse=0, err_cnt=0, expected=0x00, internal counters 0. rst_n dominates din_valid and err_clr.

## Configuration
- LFSR_CHK_ERRCNT_EN defined: err_cnt counter and err_clr logic implemented as above.
- Not defined: no counter flops; err_cnt tied to 0, err_clr ignored; err_pulse, lock and state behaviour unchanged.

## Test plan
- Reset, then valid beats 0x01,0x02,0x04,0x08,0x10 → state SYNC after first, locked=1 the cycle after 0x10; expected=0x20.
- Locked, continue 0x20,0x40, send 0x55 instead of 0x80, then 0x63 → single err_pulse, err_cnt=1, locked stays 1, 0x63 accepted via flywheel.
- Locked, three consecutive wrong words (0xAA,0xAA,0xAA) → err_pulse three cycles, err_cnt=3, locked falls after third, state=HUNT.
- From reset, valid beats of 0x00 for 20 cycles → state remains HUNT, locked=0, err_cnt=0.
- ERR_W=4, locked, alternate wrong/correct beats 20 times → err_cnt saturates at 15, lock held; err_clr on a mismatching beat → err_cnt=0 next cycle.
- Locked with err_cnt=2, assert rst_n=0 one cycle → all outputs zero/HUNT next cycle; without LFSR_CHK_ERRCNT_EN, err_cnt reads 0 throughout all scenarios.
